ps2_rx_deserializer: RTL
========================

Name: ps2_rx_deserializer

Overview:
- Receive-side PHY for the PS/2 mouse path.
- Samples the open-collector PS2_CLK/PS2_DAT lines and deserializes each 11-bit device-to-host frame.
- Checks start, odd-parity and stop bits, then presents one byte per frame as a single-cycle strobe.
- Sits directly upstream of the mouse packet assembler, which consumes the received_data / received_data_en pair.
- Tristate drivers and the host-to-device transmit path live outside this block.

Parameters:
- CLK_HZ, 50000000, system clock frequency; used only to document TIMEOUT_CYCLES.
- TIMEOUT_CYCLES, 100000, idle CLOCK_50 cycles (2 ms) inside a frame before the frame is abandoned.
- FILTER_LEN, 8, glitch-filter depth in CLOCK_50 cycles; used only when the optional feature is compiled in.

Ports:
- CLOCK_50  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- ps2_clk_in  input  1  raw PS2_CLK line level (asynchronous).
- ps2_dat_in  input  1  raw PS2_DAT line level (asynchronous).
- received_data  output  8  last good byte, LSB first on the wire.
- received_data_en  output  1  one-cycle strobe: received_data is valid this cycle.
- parity_error  output  1  one-cycle strobe: frame discarded for bad parity.
- frame_error  output  1  one-cycle strobe: frame discarded for bad start bit, bad stop bit or timeout.
- busy  output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset (reset_n low, asynchronous):
  - received_data = 8'h00; received_data_en, parity_error, frame_error, busy = 0.
  - FSM enters IDLE; bit counter and timeout counter cleared.
  - Synchronizer flops preset to 1 (bus idle-high).
- Input conditioning:
  - Each line passes through a 2-flop synchronizer.
  - A falling-edge detect on the synchronized clock (prev=1, cur=0) produces fall_tick.
  - Data is sampled from the synchronized data line on the same cycle as fall_tick.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall_tick with data=0 (start bit), go to DATA and clear bit_cnt. On fall_tick with data=1, pulse frame_error and stay in IDLE.
  - DATA: each fall_tick shifts data into shreg[7] with a right-shift, so LSB arrives first; bit_cnt increments. After the 8th bit, go to PARITY.
  - PARITY: on fall_tick, latch parity bit p and go to STOP.
  - STOP: on fall_tick, check the sampled bit:
    - If stop=1 and ^{shreg,p}==1 (odd parity OK): received_data <= shreg and received_data_en=1 on the next cycle.
    - If stop=1 and parity is bad: parity_error pulses instead; received_data is unchanged.
    - If stop=0: frame_error pulses; parity is not reported.
    - All three cases return to IDLE.
- Latency: received_data_en is high exactly 1 cycle after the STOP-state fall_tick. fall_tick lags the raw pin edge by 2–3 CLOCK_50 cycles (synchronizer uncertainty).
- Strobes:
  - At most one of received_data_en / parity_error / frame_error is high in any cycle.
  - Each strobe is exactly one cycle wide, never back-to-back for the same frame.
- Timeout:
  - The timeout counter clears on every fall_tick and increments in any non-IDLE state.
  - On reaching TIMEOUT_CYCLES-1: pulse frame_error, return to IDLE, discard the partial byte.
  - The counter saturates and does not wrap.
- Edge cases:
  - A fall_tick on the same cycle as the timeout terminal count: the timeout wins and the edge is ignored.
  - reset_n asserted mid-frame aborts immediately with no strobe.
  - The first frame after reset is accepted normally.
- received_data holds its value between strobes; downstream may read it any time.
- busy = (state != IDLE).

Optional Feature:
- Macro: PS2_RX_GLITCH_FILTER_EN.
- Defined:
  - Each synchronized line feeds a FILTER_LEN-cycle stability filter. The filtered output changes only after the input holds a new level for FILTER_LEN consecutive cycles.
  - Edge detect and data sampling use the filtered signals.
  - Latency increases by FILTER_LEN cycles.
  - Pulses shorter than FILTER_LEN cycles are invisible.
- Undefined: the filter is absent and the synchronizer feeds edge detect directly; FILTER_LEN is unused.

Test Plan:
- Frame 0x08 (start 0, bits 0,0,0,1,0,0,0,0, parity 0, stop 1), 12.5 kHz PS2 clock: one received_data_en pulse with received_data=8'h08; no error strobes.
- Frame 0xFA with parity forced to 0 (correct value 1): parity_error pulses once; received_data still holds the previous byte (8'h08); no received_data_en.
- Frame 0x00 (parity 1) with stop bit driven 0: frame_error pulses once; busy drops to 0 in the same cycle.
- Start bit plus 4 data bits, then the clock held high for 2 ms: frame_error after exactly TIMEOUT_CYCLES idle cycles; a following full 0x55 frame (parity 1) gives received_data=8'h55.
- Three back-to-back mouse packet bytes 0x09, 0x10, 0xF0: exactly three received_data_en strobes, in order, with those values.
- reset_n pulsed low during the 5th data bit, then a full 0xAA frame: no strobe from the aborted frame; received_data=8'hAA afterwards. With PS2_RX_GLITCH_FILTER_EN defined, add a 3-cycle low glitch on ps2_clk_in mid-bit: the byte is still received correctly.

Source files
------------

// File: rtl/ps2_rx_deserializer.sv
// PS/2 device-to-host receiver: synchronizes PS2_CLK/PS2_DAT, deserializes 11-bit frames,
// checks start/odd-parity/stop and emits one byte per good frame. Optional macro: PS2_RX_GLITCH_FILTER_EN.
module ps2_rx_deserializer #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int TIMEOUT_CYCLES = 100_000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic [7:0] received_data,
  output logic       received_data_en,
  output logic       parity_error,
  output logic       frame_error,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Reject configurations that cannot work; CLK_HZ only documents the timeout in seconds.
  if (CLK_HZ <= 0 || TIMEOUT_CYCLES < 2 || FILTER_LEN < 2) begin : g_bad_cfg
    $error("ps2_rx_deserializer: invalid parameter set");
  end

  state_t        state, state_nxt;
  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_f, dat_f, clk_prev;
  logic          fall_tick;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [2:0]    bit_cnt;
  logic [TW-1:0] to_cnt;
  logic          timeout_hit;
  logic          start_en, shift_en, par_en;
  logic          good_nxt, par_err_nxt, frm_err_nxt;

  // Synchronizers preset high so reset looks like an idle bus.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk_in;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat_in;
      dat_s2 <= dat_s1;
    end
  end

`ifdef PS2_RX_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN);
  logic [FW-1:0] clk_fcnt, dat_fcnt;

  // A filtered line follows its input only after FILTER_LEN consecutive differing cycles.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      clk_f    <= 1'b1;
      dat_f    <= 1'b1;
      clk_fcnt <= '0;
      dat_fcnt <= '0;
    end else begin
      if (clk_s2 == clk_f) begin
        clk_fcnt <= '0;
      end else if (clk_fcnt == FW'(FILTER_LEN - 1)) begin
        clk_f    <= clk_s2;
        clk_fcnt <= '0;
      end else begin
        clk_fcnt <= clk_fcnt + 1'b1;
      end
      if (dat_s2 == dat_f) begin
        dat_fcnt <= '0;
      end else if (dat_fcnt == FW'(FILTER_LEN - 1)) begin
        dat_f    <= dat_s2;
        dat_fcnt <= '0;
      end else begin
        dat_fcnt <= dat_fcnt + 1'b1;
      end
    end
  end
`else
  assign clk_f = clk_s2;
  assign dat_f = dat_s2;
`endif

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) clk_prev <= 1'b1;
    else          clk_prev <= clk_f;
  end

  assign fall_tick   = clk_prev & ~clk_f;
  assign timeout_hit = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign busy        = (state != IDLE);

  // State register
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; a timeout on the same cycle as an edge takes precedence.
  always_comb begin
    state_nxt = state;
    if (timeout_hit) begin
      state_nxt = IDLE;
    end else if (fall_tick) begin
      case (state)
        IDLE:    if (!dat_f) state_nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output / datapath-control logic
  always_comb begin
    start_en    = 1'b0;
    shift_en    = 1'b0;
    par_en      = 1'b0;
    good_nxt    = 1'b0;
    par_err_nxt = 1'b0;
    frm_err_nxt = 1'b0;
    if (timeout_hit) begin
      frm_err_nxt = 1'b1;
    end else if (fall_tick) begin
      case (state)
        IDLE: begin
          start_en    = ~dat_f;
          frm_err_nxt = dat_f;
        end
        DATA:   shift_en = 1'b1;
        PARITY: par_en   = 1'b1;
        STOP: begin
          if (!dat_f)                  frm_err_nxt = 1'b1;
          else if (^{shreg, par_bit})  good_nxt    = 1'b1;
          else                         par_err_nxt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      shreg            <= 8'h00;
      par_bit          <= 1'b0;
      bit_cnt          <= 3'd0;
      received_data    <= 8'h00;
      received_data_en <= 1'b0;
      parity_error     <= 1'b0;
      frame_error      <= 1'b0;
    end else begin
      if (start_en) bit_cnt <= 3'd0;
      if (shift_en) begin
        shreg   <= {dat_f, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (par_en)   par_bit <= dat_f;
      if (good_nxt) received_data <= shreg;
      received_data_en <= good_nxt;
      parity_error     <= par_err_nxt;
      frame_error      <= frm_err_nxt;
    end
  end

  // Inactivity counter: restarts on every edge, saturates at the terminal count.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n)                                to_cnt <= '0;
    else if (fall_tick || state == IDLE)         to_cnt <= '0;
    else if (to_cnt != TW'(TIMEOUT_CYCLES - 1))  to_cnt <= to_cnt + 1'b1;
  end

endmodule
